// File: rtl/cart_sdram_arbiter.sv
// Cartridge SDRAM port arbiter: ioctl loader byte writes vs Z80 cartridge
// reads, with a one-entry read cache in front of the SDRAM controller.
module cart_sdram_arbiter #(
   parameter int ADDR_W     = 25,
   parameter int STARVE_MAX = 8,
   parameter bit CACHE_EN   = 1'b1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              ioctl_wr,
   input  logic [ADDR_W-1:0] ioctl_addr,
   input  logic [7:0]        ioctl_dout,
   output logic              ioctl_wait,
   input  logic              cpu_rd,
   input  logic [ADDR_W-1:0] cpu_addr,
   output logic [7:0]        cpu_data,
   output logic              cpu_valid,
   output logic              cpu_wait,
   output logic              ram_req,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [7:0]        ram_din,
   input  logic              ram_ack,
   input  logic [7:0]        ram_dout
);

   localparam int SW = $clog2(STARVE_MAX + 1);

   typedef enum logic [1:0] {IDLE, RD, WR} state_t;
   state_t state, state_nx;

   logic              pend_wr, pend_rd;
   logic [ADDR_W-1:0] wr_addr, rd_addr;
   logic [7:0]        wr_data;
   logic [SW-1:0]     starve_cnt;
   logic              cache_valid;
   logic [ADDR_W-1:0] cache_addr;
   logic [7:0]        cache_data;

   logic wr_take, rd_take, rd_hit, starved;
   logic grant_rd, grant_wr, rd_done, wr_done;

   assign ioctl_wait = pend_wr;
   assign cpu_wait   = pend_rd;

   always_comb begin
      wr_take = ioctl_wr & ~pend_wr;
      rd_take = cpu_rd & ~pend_rd;
      // A write queued (or arriving now) to the same byte makes the cache stale
      rd_hit  = CACHE_EN && cache_valid && (cpu_addr == cache_addr)
                && !(pend_wr && (wr_addr == cpu_addr))
                && !(wr_take && (ioctl_addr == cpu_addr));
      starved = pend_wr && (starve_cnt >= SW'(STARVE_MAX));
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      grant_rd = 1'b0;
      grant_wr = 1'b0;
      rd_done  = 1'b0;
      wr_done  = 1'b0;
      unique case (state)
         IDLE: begin
            if (pend_rd && !starved) begin
               grant_rd = 1'b1;
               state_nx = RD;
            end else if (pend_wr) begin
               grant_wr = 1'b1;
               state_nx = WR;
            end
         end
         RD: begin
            if (ram_ack) begin
               rd_done  = 1'b1;
               state_nx = IDLE;
            end
         end
         WR: begin
            if (ram_ack) begin
               wr_done  = 1'b1;
               state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pend_wr     <= 1'b0;
         pend_rd     <= 1'b0;
         wr_addr     <= '0;
         wr_data     <= '0;
         rd_addr     <= '0;
         starve_cnt  <= '0;
         cache_valid <= 1'b0;
         cache_addr  <= '0;
         cache_data  <= '0;
         cpu_data    <= 8'hFF;
         cpu_valid   <= 1'b0;
         ram_req     <= 1'b0;
         ram_we      <= 1'b0;
         ram_addr    <= '0;
         ram_din     <= '0;
      end else begin
         cpu_valid <= 1'b0;

         if (wr_take) begin
            pend_wr <= 1'b1;
            wr_addr <= ioctl_addr;
            wr_data <= ioctl_dout;
         end else if (wr_done) begin
            pend_wr <= 1'b0;
         end

         if (rd_take) begin
            if (rd_hit) begin
               cpu_data  <= cache_data;
               cpu_valid <= 1'b1;
            end else begin
               pend_rd <= 1'b1;
               rd_addr <= cpu_addr;
            end
         end else if (rd_done) begin
            pend_rd   <= 1'b0;
            cpu_data  <= ram_dout;
            cpu_valid <= 1'b1;
         end

         if (rd_done) begin
            cache_valid <= 1'b1;
            cache_addr  <= rd_addr;
            cache_data  <= ram_dout;
         end else if (wr_done && (wr_addr == cache_addr)) begin
            cache_valid <= 1'b0;
         end

         if (grant_rd) begin
            ram_req  <= 1'b1;
            ram_we   <= 1'b0;
            ram_addr <= rd_addr;
         end else if (grant_wr) begin
            ram_req  <= 1'b1;
            ram_we   <= 1'b1;
            ram_addr <= wr_addr;
            ram_din  <= wr_data;
         end else if (rd_done || wr_done) begin
            ram_req <= 1'b0;
            ram_we  <= 1'b0;
         end

         if (grant_wr)
            starve_cnt <= '0;
         else if (pend_wr && (state != WR) && (starve_cnt < SW'(STARVE_MAX)))
            starve_cnt <= starve_cnt + SW'(1);
      end
   end

endmodule

// File: tb/tb_cart_sdram_arbiter.sv
// Bench for cart_sdram_arbiter: cached and uncached instances run in lockstep
// against a transaction-level reference model and a behavioural SDRAM.
module tb_cart_sdram_arbiter;

   localparam int AW   = 25;
   localparam int SMAX = 8;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   logic          ioctl_wr = 1'b0;
   logic [AW-1:0] ioctl_addr = '0;
   logic [7:0]    ioctl_dout = '0;
   logic          cpu_rd = 1'b0;
   logic [AW-1:0] cpu_addr = '0;

   logic [1:0]         ioctl_wait, cpu_valid, cpu_wait, ram_req, ram_we;
   logic [1:0]         ram_ack = '0;
   logic [1:0][7:0]    cpu_data, ram_din;
   logic [1:0][7:0]    ram_dout = '0;
   logic [1:0][AW-1:0] ram_addr;

   cart_sdram_arbiter #(.ADDR_W(AW), .STARVE_MAX(SMAX), .CACHE_EN(1'b1)) u_c (
      .clk        (clk),
      .reset      (reset),
      .ioctl_wr   (ioctl_wr),
      .ioctl_addr (ioctl_addr),
      .ioctl_dout (ioctl_dout),
      .ioctl_wait (ioctl_wait[0]),
      .cpu_rd     (cpu_rd),
      .cpu_addr   (cpu_addr),
      .cpu_data   (cpu_data[0]),
      .cpu_valid  (cpu_valid[0]),
      .cpu_wait   (cpu_wait[0]),
      .ram_req    (ram_req[0]),
      .ram_we     (ram_we[0]),
      .ram_addr   (ram_addr[0]),
      .ram_din    (ram_din[0]),
      .ram_ack    (ram_ack[0]),
      .ram_dout   (ram_dout[0])
   );

   cart_sdram_arbiter #(.ADDR_W(AW), .STARVE_MAX(SMAX), .CACHE_EN(1'b0)) u_n (
      .clk        (clk),
      .reset      (reset),
      .ioctl_wr   (ioctl_wr),
      .ioctl_addr (ioctl_addr),
      .ioctl_dout (ioctl_dout),
      .ioctl_wait (ioctl_wait[1]),
      .cpu_rd     (cpu_rd),
      .cpu_addr   (cpu_addr),
      .cpu_data   (cpu_data[1]),
      .cpu_valid  (cpu_valid[1]),
      .cpu_wait   (cpu_wait[1]),
      .ram_req    (ram_req[1]),
      .ram_we     (ram_we[1]),
      .ram_addr   (ram_addr[1]),
      .ram_din    (ram_din[1]),
      .ram_ack    (ram_ack[1]),
      .ram_dout   (ram_dout[1])
   );

   // ph: 0 no transaction, 1 read on the bus, 2 write on the bus
   typedef struct packed {
      int            ph;
      int            wt;
      int            rcnt;
      int            rdly;
      bit            pw;
      bit            pr;
      bit            cv;
      bit            req;
      bit            we;
      bit            val;
      logic [AW-1:0] wa;
      logic [AW-1:0] ra;
      logic [AW-1:0] ca;
      logic [AW-1:0] addr;
      logic [7:0]    wd;
      logic [7:0]    cd;
      logic [7:0]    din;
      logic [7:0]    cpu_d;
   } mdl_t;

   mdl_t       m [2];
   logic [7:0] mem [2][16];
   int         n_vec = 0;
   int         n_err = 0;
   int         cyc = 0;
   int         fix_dly = 2;
   int         stray_pct = 0;

   task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
      n_vec++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   task automatic check_all(int k);
      string p;
      p = (k == 0) ? "cached." : "uncached.";
      chk({p, "ram_req"},    32'(ram_req[k]),    32'(m[k].req));
      chk({p, "ram_we"},     32'(ram_we[k]),     32'(m[k].we));
      chk({p, "ram_addr"},   32'(ram_addr[k]),   32'(m[k].addr));
      chk({p, "ram_din"},    32'(ram_din[k]),    32'(m[k].din));
      chk({p, "cpu_data"},   32'(cpu_data[k]),   32'(m[k].cpu_d));
      chk({p, "cpu_valid"},  32'(cpu_valid[k]),  32'(m[k].val));
      chk({p, "cpu_wait"},   32'(cpu_wait[k]),   32'(m[k].pr));
      chk({p, "ioctl_wait"}, 32'(ioctl_wait[k]), 32'(m[k].pw));
   endtask

   task automatic model_reset(int k);
      m[k] = '0;
      m[k].cpu_d = 8'hFF;
   endtask

   // Behavioural SDRAM: acks a held request after rdly idle cycles
   task automatic respond(int k);
      if (m[k].req) begin
         if (m[k].rcnt >= m[k].rdly) begin
            ram_ack[k] = 1'b1;
            if (m[k].we) begin
               mem[k][m[k].addr[3:0]] = m[k].din;
               ram_dout[k] = 8'($urandom);
            end else begin
               ram_dout[k] = mem[k][m[k].addr[3:0]];
            end
         end else begin
            ram_ack[k] = 1'b0;
            m[k].rcnt++;
         end
      end else begin
         ram_ack[k]  = ($urandom_range(0, 99) < stray_pct);
         ram_dout[k] = 8'($urandom);
      end
   endtask

   task automatic model_edge(int k, bit w, logic [AW-1:0] wa, logic [7:0] wd,
                             bit r, logic [AW-1:0] ra, bit ack, logic [7:0] dout);
      mdl_t o, n;
      int   waited;
      bit   ce;
      ce = (k == 0);
      o = m[k];
      n = o;
      n.val = 1'b0;
      if (o.ph == 1 && ack) begin
         n.cpu_d = dout;
         n.val   = 1'b1;
         n.pr    = 1'b0;
         n.cv    = 1'b1;
         n.ca    = o.ra;
         n.cd    = dout;
         n.req   = 1'b0;
         n.we    = 1'b0;
         n.ph    = 0;
      end else if (o.ph == 2 && ack) begin
         n.pw  = 1'b0;
         if (o.wa == o.ca) n.cv = 1'b0;
         n.req = 1'b0;
         n.we  = 1'b0;
         n.ph  = 0;
      end else if (o.ph == 0) begin
         // cycles the queued write has spent losing, measured from its capture
         waited = o.pw ? (cyc - 1 - o.wt) : 0;
         if (o.pr && !(o.pw && waited >= SMAX)) begin
            n.ph   = 1;
            n.req  = 1'b1;
            n.we   = 1'b0;
            n.addr = o.ra;
         end else if (o.pw) begin
            n.ph   = 2;
            n.req  = 1'b1;
            n.we   = 1'b1;
            n.addr = o.wa;
            n.din  = o.wd;
         end
         if (n.ph != 0) begin
            n.rcnt = 0;
            n.rdly = (fix_dly >= 0) ? fix_dly : int'($urandom_range(0, 3));
         end
      end
      if (w && !o.pw) begin
         n.pw = 1'b1;
         n.wa = wa;
         n.wd = wd;
         n.wt = cyc;
      end
      if (r && !o.pr) begin
         if (ce && o.cv && ra == o.ca && !(o.pw && o.wa == ra)
             && !(w && !o.pw && wa == ra)) begin
            n.cpu_d = o.cd;
            n.val   = 1'b1;
         end else begin
            n.pr = 1'b1;
            n.ra = ra;
         end
      end
      m[k] = n;
   endtask

   task automatic step(bit w, logic [AW-1:0] wa, logic [7:0] wd,
                       bit r, logic [AW-1:0] ra);
      respond(0);
      respond(1);
      ioctl_wr   = w;
      ioctl_addr = wa;
      ioctl_dout = wd;
      cpu_rd     = r;
      cpu_addr   = ra;
      @(posedge clk);
      #1;
      for (int k = 0; k < 2; k++)
         model_edge(k, w, wa, wd, r, ra, ram_ack[k], ram_dout[k]);
      cyc++;
      ioctl_wr = 1'b0;
      cpu_rd   = 1'b0;
      for (int k = 0; k < 2; k++) check_all(k);
   endtask

   task automatic idle(int n);
      for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, '0);
   endtask

   initial begin
      for (int k = 0; k < 2; k++) begin
         for (int i = 0; i < 16; i++) mem[k][i] = 8'(i * 37 + 5);
         mem[k][0] = 8'hC3;
         model_reset(k);
      end
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      for (int k = 0; k < 2; k++) check_all(k);

      // cold read, ack three cycles after the request
      step(1'b0, '0, '0, 1'b1, 25'h004000);
      idle(7);
      // repeat read: cache hit on one instance, SDRAM read on the other
      step(1'b0, '0, '0, 1'b1, 25'h004000);
      idle(7);
      // loader write invalidates the cached byte
      step(1'b1, 25'h004000, 8'h55, 1'b0, '0);
      idle(7);
      step(1'b0, '0, '0, 1'b1, 25'h004000);
      idle(7);

      // simultaneous capture, then reads hammered every cycle
      fix_dly = 0;
      step(1'b1, 25'h004001, 8'hA7, 1'b1, 25'h004002);
      for (int i = 0; i < 24; i++)
         step(1'b0, '0, '0, 1'b1, AW'(25'h004004 + (i % 8)));
      idle(4);

      // second write and second read while busy are dropped
      fix_dly = 2;
      step(1'b1, 25'h004005, 8'h11, 1'b1, 25'h004006);
      step(1'b1, 25'h004006, 8'h22, 1'b1, 25'h004007);
      idle(12);
      step(1'b0, '0, '0, 1'b1, 25'h004006);
      idle(8);

      // randomized traffic with random latency and stray acks
      fix_dly   = -1;
      stray_pct = 15;
      for (int i = 0; i < 300; i++)
         step($urandom_range(0, 3) == 0, AW'(25'h004000 + $urandom_range(0, 7)),
              8'($urandom), $urandom_range(0, 2) == 0,
              AW'(25'h004000 + $urandom_range(0, 7)));
      stray_pct = 0;
      idle(10);

      // reset in the middle of a read abandons it at once
      fix_dly = 3;
      step(1'b1, 25'h004009, 8'h3C, 1'b1, 25'h00400A);
      idle(1);
      #2;
      reset = 1'b1;
      #1;
      for (int k = 0; k < 2; k++) begin
         model_reset(k);
         check_all(k);
      end
      @(posedge clk);
      #1;
      reset = 1'b0;
      stray_pct = 100;
      idle(2);
      stray_pct = 0;
      step(1'b0, '0, '0, 1'b1, 25'h00400B);
      idle(8);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
